// File: rtl/axi_burst_mem_slave.sv
// rtl/axi_burst_mem_slave.sv - AXI4 burst memory slave with read latency, error responses, optional back-pressure
// Purpose: serves independent AXI4 read and write bursts from an internal DATA_W-wide word array.
//   Write path: W_IDLE -> W_DATA -> W_RESP, one burst outstanding.
//   Read path:  R_IDLE -> R_WAIT (RD_LAT cycles) -> R_DATA.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   aw*_s_inf / w*_s_inf / b*_s_inf   write address, write data, write response channels
//   ar*_s_inf / r*_s_inf              read address, read data channels
// Option: define AXI_MEM_BACKPRESSURE_EN to throttle awready/wready/arready and to
//   insert idle cycles between read beats from a 16-bit LFSR.
module axi_burst_mem_slave #(
   parameter int          DATA_W    = 128,
   parameter int          ADDR_W    = 32,
   parameter int          ID_W      = 4,
   parameter int          DEPTH     = 8192,
   parameter int          RD_LAT    = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   awid_s_inf,
   input  logic [ADDR_W-1:0] awaddr_s_inf,
   input  logic [2:0]        awsize_s_inf,
   input  logic [1:0]        awburst_s_inf,
   input  logic [7:0]        awlen_s_inf,
   input  logic              awvalid_s_inf,
   output logic              awready_s_inf,
   input  logic [DATA_W-1:0] wdata_s_inf,
   input  logic              wlast_s_inf,
   input  logic              wvalid_s_inf,
   output logic              wready_s_inf,
   output logic [ID_W-1:0]   bid_s_inf,
   output logic [1:0]        bresp_s_inf,
   output logic              bvalid_s_inf,
   input  logic              bready_s_inf,
   input  logic [ID_W-1:0]   arid_s_inf,
   input  logic [ADDR_W-1:0] araddr_s_inf,
   input  logic [7:0]        arlen_s_inf,
   input  logic [2:0]        arsize_s_inf,
   input  logic [1:0]        arburst_s_inf,
   input  logic              arvalid_s_inf,
   output logic              arready_s_inf,
   output logic [ID_W-1:0]   rid_s_inf,
   output logic [DATA_W-1:0] rdata_s_inf,
   output logic [1:0]        rresp_s_inf,
   output logic              rlast_s_inf,
   output logic              rvalid_s_inf,
   input  logic              rready_s_inf
);
   localparam int SH = $clog2(DATA_W/8);
   localparam int IW = ADDR_W - SH + 1;   // extra bit so INCR never wraps back into range
   localparam int MW = $clog2(DEPTH);
   localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
   localparam logic [2:0]    SIZE_OK = 3'(SH);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

   logic [DATA_W-1:0] mem_q [DEPTH];

   w_state_e          w_state_q, w_state_d;
   logic [ID_W-1:0]   w_id_q, w_id_d;
   logic [IW-1:0]     w_idx_q, w_idx_d;
   logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic              w_fixed_q, w_fixed_d, w_cmderr_q, w_cmderr_d;
   logic              w_decerr_q, w_decerr_d, w_lasterr_q, w_lasterr_d;
   logic [1:0]        bresp_q, bresp_d;
   r_state_e          r_state_q, r_state_d;
   logic [ID_W-1:0]   r_id_q, r_id_d;
   logic [IW-1:0]     r_idx_q, r_idx_d, r_fetch_idx;
   logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d, r_beat;
   logic              r_fixed_q, r_fixed_d, r_cmderr_q, r_cmderr_d;
   logic [3:0]        r_lat_q, r_lat_d;
   logic              r_gap_q, r_gap_d, rlast_q, rlast_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              init_q, init_d;
   logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, r_load, mem_we;
   logic              w_last_beat, w_beat_dec;
   logic              bp_aw, bp_w, bp_ar, gap_req;
   logic              unused_bits;

   assign unused_bits = ^{awaddr_s_inf[SH-1:0], araddr_s_inf[SH-1:0], LFSR_SEED};

`ifdef AXI_MEM_BACKPRESSURE_EN
   logic [15:0] lfsr_q, lfsr_d;
   assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign bp_aw   = lfsr_q[0];
   assign bp_ar   = lfsr_q[1];
   assign bp_w    = lfsr_q[2];
   assign gap_req = lfsr_q[3];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end
`else
   assign bp_aw   = 1'b1;
   assign bp_ar   = 1'b1;
   assign bp_w    = 1'b1;
   assign gap_req = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q <= W_IDLE;  w_id_q <= '0;  w_idx_q <= '0;  w_len_q <= '0;  w_cnt_q <= '0;
         w_fixed_q <= 1'b0;  w_cmderr_q <= 1'b0;  w_decerr_q <= 1'b0;  w_lasterr_q <= 1'b0;
         bresp_q <= '0;
         r_state_q <= R_IDLE;  r_id_q <= '0;  r_idx_q <= '0;  r_len_q <= '0;  r_cnt_q <= '0;
         r_fixed_q <= 1'b0;  r_cmderr_q <= 1'b0;  r_lat_q <= '0;  r_gap_q <= 1'b0;
         rlast_q <= 1'b0;  rdata_q <= '0;  rresp_q <= '0;  init_q <= 1'b0;
      end else begin
         w_state_q <= w_state_d;  w_id_q <= w_id_d;  w_idx_q <= w_idx_d;  w_len_q <= w_len_d;
         w_cnt_q <= w_cnt_d;  w_fixed_q <= w_fixed_d;  w_cmderr_q <= w_cmderr_d;
         w_decerr_q <= w_decerr_d;  w_lasterr_q <= w_lasterr_d;  bresp_q <= bresp_d;
         r_state_q <= r_state_d;  r_id_q <= r_id_d;  r_idx_q <= r_idx_d;  r_len_q <= r_len_d;
         r_cnt_q <= r_cnt_d;  r_fixed_q <= r_fixed_d;  r_cmderr_q <= r_cmderr_d;
         r_lat_q <= r_lat_d;  r_gap_q <= r_gap_d;  rlast_q <= rlast_d;  rdata_q <= rdata_d;
         rresp_q <= rresp_d;  init_q <= init_d;
      end
   end

   // Memory is deliberately not reset; a burst cut by reset keeps the beats it already wrote
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[w_idx_q[MW-1:0]] <= wdata_s_inf;
   end

   assign aw_hs       = awvalid_s_inf & awready_s_inf;
   assign w_hs        = wvalid_s_inf & wready_s_inf;
   assign b_hs        = bvalid_s_inf & bready_s_inf;
   assign ar_hs       = arvalid_s_inf & arready_s_inf;
   assign r_hs        = rvalid_s_inf & rready_s_inf;
   assign w_last_beat = (w_cnt_q == w_len_q);
   assign w_beat_dec  = (w_idx_q >= DEPTH_I);
   // A beat is fetched when the latency wait expires and after every non-final R handshake
   assign r_load      = ((r_state_q == R_WAIT) && (r_lat_q == 4'd0)) || (r_hs && !rlast_q);

   // Next-state logic
   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE:  if (aw_hs) w_state_d = W_DATA;
         W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
         W_RESP:  if (b_hs) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_hs) r_state_d = R_WAIT;
         R_WAIT:  if (r_lat_q == 4'd0) r_state_d = R_DATA;
         R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // Datapath: burst bookkeeping, error accumulation, read beat fetch
   always_comb begin
      init_d = 1'b1;
      w_id_d = w_id_q;  w_idx_d = w_idx_q;  w_len_d = w_len_q;  w_cnt_d = w_cnt_q;
      w_fixed_d = w_fixed_q;  w_cmderr_d = w_cmderr_q;  w_decerr_d = w_decerr_q;
      w_lasterr_d = w_lasterr_q;  bresp_d = bresp_q;  mem_we = 1'b0;
      if (aw_hs) begin
         w_id_d = awid_s_inf;  w_idx_d = {1'b0, awaddr_s_inf[ADDR_W-1:SH]};
         w_len_d = awlen_s_inf;  w_cnt_d = '0;  w_fixed_d = (awburst_s_inf == 2'b00);
         w_cmderr_d = awburst_s_inf[1] | (awsize_s_inf != SIZE_OK);
         w_decerr_d = 1'b0;  w_lasterr_d = 1'b0;
      end
      if (w_hs) begin
         mem_we      = !w_cmderr_q && !w_beat_dec;
         w_idx_d     = w_fixed_q ? w_idx_q : w_idx_q + 1'b1;
         w_cnt_d     = w_cnt_q + 1'b1;
         w_decerr_d  = w_decerr_q | w_beat_dec;
         w_lasterr_d = w_lasterr_q | (wlast_s_inf != w_last_beat);
         if (w_last_beat)
            bresp_d = w_cmderr_q ? 2'b10 : w_decerr_d ? 2'b11 : w_lasterr_d ? 2'b10 : 2'b00;
      end

      r_id_d = r_id_q;  r_idx_d = r_idx_q;  r_len_d = r_len_q;  r_cnt_d = r_cnt_q;
      r_fixed_d = r_fixed_q;  r_cmderr_d = r_cmderr_q;  r_lat_d = r_lat_q;
      rlast_d = rlast_q;  rdata_d = rdata_q;  rresp_d = rresp_q;
      r_gap_d = r_hs && !rlast_q && gap_req;
      r_fetch_idx = (r_state_q == R_WAIT || r_fixed_q) ? r_idx_q : r_idx_q + 1'b1;
      r_beat      = (r_state_q == R_WAIT) ? 8'd0 : r_cnt_q + 1'b1;
      if (ar_hs) begin
         r_id_d = arid_s_inf;  r_idx_d = {1'b0, araddr_s_inf[ADDR_W-1:SH]};
         r_len_d = arlen_s_inf;  r_fixed_d = (arburst_s_inf == 2'b00);
         r_cmderr_d = arburst_s_inf[1] | (arsize_s_inf != SIZE_OK);
         r_lat_d = 4'(RD_LAT - 1);
      end else if (r_state_q == R_WAIT && r_lat_q != 4'd0) begin
         r_lat_d = r_lat_q - 1'b1;
      end
      if (r_load) begin
         r_idx_d = r_fetch_idx;  r_cnt_d = r_beat;  rlast_d = (r_beat == r_len_q);
         if (r_cmderr_q) begin
            rdata_d = '0;  rresp_d = 2'b10;
         end else if (r_fetch_idx >= DEPTH_I) begin
            rdata_d = '0;  rresp_d = 2'b11;
         end else begin
            rdata_d = mem_q[r_fetch_idx[MW-1:0]];  rresp_d = 2'b00;
         end
      end
   end

   // Outputs; init_q holds the readies low during reset and the cycle after it
   always_comb begin
      awready_s_inf = init_q && (w_state_q == W_IDLE) && bp_aw;
      wready_s_inf  = (w_state_q == W_DATA) && bp_w;
      bvalid_s_inf  = (w_state_q == W_RESP);
      bid_s_inf     = w_id_q;
      bresp_s_inf   = bresp_q;
      arready_s_inf = init_q && (r_state_q == R_IDLE) && bp_ar;
      rvalid_s_inf  = (r_state_q == R_DATA) && !r_gap_q;
      rid_s_inf     = r_id_q;
      rdata_s_inf   = rdata_q;
      rresp_s_inf   = rresp_q;
      rlast_s_inf   = rlast_q;
   end
endmodule
